potential_adder_scheduler: RTL

//  Time-multiplexes one shared FP32 potential adder across NUM_NEURONS neurons in the accelerator.

---
 rtl/potential_adder_scheduler_if.sv | 24 ++
 rtl/potential_adder_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/potential_adder_scheduler_if.sv
// Requester and shared-adder handshake bundle for the potential adder scheduler.
// The master modport is the scheduler; the slave modport is the neurons plus the adder.
interface potential_adder_scheduler_if #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = 32
);
  logic [NUM_NEURONS-1:0]        req;
  logic [NUM_NEURONS-1:0]        grant;
  logic [NUM_NEURONS*DATA_W-1:0] weight_flat;
  logic                          add_start;
  logic [DATA_W-1:0]             add_a;
  logic [DATA_W-1:0]             add_b;
  logic                          add_done;
  logic [DATA_W-1:0]             add_result;

  modport master (
    input  req, weight_flat, add_done, add_result,
    output grant, add_start, add_a, add_b
  );
  modport slave (
    output req, weight_flat, add_done, add_result,
    input  grant, add_start, add_a, add_b
  );
endinterface

// File: rtl/potential_adder_scheduler.sv
// Shares one FP32 adder across NUM_NEURONS membrane potentials: round-robin grant,
// start/done sequencing, write-back, and end-of-timestep drain detection.
module potential_adder_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4,
  parameter int DATA_W      = 32
) (
  input  logic                          CLK,
  input  logic                          clear_n,
  input  logic                          load,
  input  logic [NUM_NEURONS*DATA_W-1:0] decayed_flat,
  input  logic                          timestep_end,
  output logic                          pot_update,
  output logic [IDX_W-1:0]              pot_idx,
  output logic [NUM_NEURONS*DATA_W-1:0] potentials_flat,
  output logic                          timestep_done,
  output logic                          busy,
  potential_adder_scheduler_if.master   bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_e;

  state_e                               state_q, state_d;
  logic [NUM_NEURONS-1:0]               grant_q, grant_d;
  logic                                 add_start_q, add_start_d;
  logic [DATA_W-1:0]                    add_a_q, add_a_d;
  logic [DATA_W-1:0]                    add_b_q, add_b_d;
  logic [NUM_NEURONS-1:0][DATA_W-1:0]   pot_q, pot_d;
  logic                                 pot_update_q, pot_update_d;
  logic [IDX_W-1:0]                     pot_idx_q, pot_idx_d;
  logic [IDX_W-1:0]                     sel_q, sel_d;
  logic [IDX_W-1:0]                     ptr_q, ptr_d;
  logic                                 done_q, done_d;
  logic                                 end_pend_q, end_pend_d;

  logic [NUM_NEURONS-1:0][DATA_W-1:0]   decayed, weight;
  logic                                 rr_hit;
  logic [IDX_W-1:0]                     rr_idx;

  assign decayed = decayed_flat;
  assign weight  = bus.weight_flat;

  // First requester at or after the pointer, wrapping past the last neuron.
  always_comb begin
    int j;
    j      = 0;
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_NEURONS) j = j - NUM_NEURONS;
      if (!rr_hit && bus.req[j]) begin
        rr_hit = 1'b1;
        rr_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = '0;
    add_start_d  = 1'b0;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    pot_d        = pot_q;
    pot_update_d = 1'b0;
    pot_idx_d    = pot_idx_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    done_d       = 1'b0;
    end_pend_d   = end_pend_q | timestep_end;
    case (state_q)
      // WRITE arbitrates like IDLE so the registered grant/done pulses land
      // one cycle after write-back; load is only honoured from true IDLE.
      IDLE, WRITE: begin
        if (state_q == IDLE && load) begin
          pot_d   = decayed;
          state_d = IDLE;
        end else if (rr_hit) begin
          grant_d[rr_idx] = 1'b1;
          sel_d           = rr_idx;
          add_a_d         = pot_q[rr_idx];
          add_b_d         = weight[rr_idx];
          ptr_d           = (rr_idx == IDX_W'(NUM_NEURONS-1)) ? '0 : rr_idx + 1'b1;
          state_d         = ISSUE;
        end else begin
          state_d = IDLE;
          if (end_pend_q || timestep_end) begin
            done_d     = 1'b1;
            end_pend_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        add_start_d = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (bus.add_done) begin
          pot_d[sel_q] = bus.add_result;
          pot_update_d = 1'b1;
          pot_idx_d    = sel_q;
          state_d      = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      add_start_q  <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      pot_q        <= '0;
      pot_update_q <= 1'b0;
      pot_idx_q    <= '0;
      sel_q        <= '0;
      ptr_q        <= '0;
      done_q       <= 1'b0;
      end_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      add_start_q  <= add_start_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      pot_q        <= pot_d;
      pot_update_q <= pot_update_d;
      pot_idx_q    <= pot_idx_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      done_q       <= done_d;
      end_pend_q   <= end_pend_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.add_start   = add_start_q;
  assign bus.add_a       = add_a_q;
  assign bus.add_b       = add_b_q;
  assign pot_update      = pot_update_q;
  assign pot_idx         = pot_idx_q;
  assign potentials_flat = pot_q;
  assign timestep_done   = done_q;
  assign busy            = (state_q != IDLE);
endmodule
